// File: rtl/mux2to1_arb_if.sv
// Bus bundle between the two sources and the arbitrated mux.
// master drives requests and data; slave returns grants and the muxed beat.
interface mux2to1_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic             last;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             valid;

  modport master (
    output req0, req1, last, in0, in1,
    input  gnt0, gnt1, sel, out, valid
  );

  modport slave (
    input  req0, req1, last, in0, in1,
    output gnt0, gnt1, sel, out, valid
  );
endinterface

// File: rtl/mux2to1_arb.sv
// Two-source round-robin arbiter with a registered output mux.
// Grants are held until the owner marks last or drops its request.
module mux2to1_arb #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  mux2to1_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_sel;
  logic             r_valid;
  logic [WIDTH-1:0] r_out;

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.sel   = r_sel;
  assign bus.out   = r_out;
  assign bus.valid = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || !r_prio)) begin
            r_state <= GNT0;
            r_gnt0  <= 1'b1;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
          end else if (bus.req1) begin
            r_state <= GNT1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b1;
            r_sel   <= 1'b1;
          end
        end
        GNT0: begin
          if (bus.req0) begin
            r_out   <= bus.in0;
            r_valid <= 1'b1;
            if (bus.last) begin
              r_prio <= 1'b1;
              r_gnt0 <= 1'b0;
              if (bus.req1) begin
                r_state <= GNT1;
                r_gnt1  <= 1'b1;
                r_sel   <= 1'b1;
              end else begin
                r_state <= IDLE;
              end
            end
          end else begin
            // abort: hand priority away so the other side is not starved
            r_prio  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_state <= IDLE;
          end
        end
        GNT1: begin
          if (bus.req1) begin
            r_out   <= bus.in1;
            r_valid <= 1'b1;
            if (bus.last) begin
              r_prio <= 1'b0;
              r_gnt1 <= 1'b0;
              if (bus.req0) begin
                r_state <= GNT0;
                r_gnt0  <= 1'b1;
                r_sel   <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end
          end else begin
            r_prio  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2to1_arb.sv
// Directed bench for mux2to1_arb.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_mux2to1_arb;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic r_acc;

  mux2to1_arb_if #(.WIDTH(8)) bus ();

  mux2to1_arb #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.last = 1'b0;
    bus.in0  = 8'h00;
    bus.in1  = 8'h00;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    #1;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_out", bus.out, 0);
    check("rst_valid", bus.valid, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // beat acceptance observed at each edge from the DUT's grants
  always @(posedge clk)
    r_acc <= !rst && ((bus.gnt0 && bus.req0) || (bus.gnt1 && bus.req1));

  always @(negedge clk) begin
    check("excl", bus.gnt0 & bus.gnt1, 0);
    check("valid_mon", bus.valid, rst ? 1'b0 : r_acc);
  end

  logic [7:0] exp_out [4];
  logic       exp_g0  [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    r_acc  = 1'b0;
    rst    = 1'b1;
    idle_in();

    // single source, then abort
    do_reset();
    bus.last = 1'b1;
    tick();
    check("t1_idle_last", {bus.gnt0, bus.gnt1}, 0);
    bus.last = 1'b0;
    bus.req0 = 1'b1;
    bus.in0  = 8'hA5;
    tick();
    check("t1_gnt0_e1", bus.gnt0, 1);
    check("t1_valid_e1", bus.valid, 0);
    check("t1_sel_e1", bus.sel, 0);
    tick();
    check("t1_valid_e2", bus.valid, 1);
    check("t1_out_e2", bus.out, 8'hA5);
    tick();
    check("t1_out_e3", bus.out, 8'hA5);
    check("t1_gnt0_e3", bus.gnt0, 1);
    bus.req0 = 1'b0;
    tick();
    check("t1_abort_gnt0", bus.gnt0, 0);
    check("t1_abort_valid", bus.valid, 0);
    check("t1_abort_out", bus.out, 8'hA5);

    // alternating back-to-back handover
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.last = 1'b1;
    bus.in0  = 8'h11;
    bus.in1  = 8'h22;
    exp_g0  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_out = '{8'h00, 8'h11, 8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_gnt0", bus.gnt0, exp_g0[i]);
      check("t2_gnt1", bus.gnt1, !exp_g0[i]);
      check("t2_sel", bus.sel, !exp_g0[i]);
      check("t2_out", bus.out, exp_out[i]);
      check("t2_valid", bus.valid, i != 0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check("t2_idle_gnt1", bus.gnt1, 0);
    check("t2_idle_valid", bus.valid, 0);
    check("t2_idle_sel", bus.sel, 1);

    // abort from GNT1 keeps prio at 0
    do_reset();
    bus.req1 = 1'b1;
    bus.in1  = 8'h5A;
    tick();
    check("t3_gnt1", bus.gnt1, 1);
    tick();
    check("t3_out", bus.out, 8'h5A);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1;
    bus.in0  = 8'hC3;
    tick();
    check("t3_abort_gnt1", bus.gnt1, 0);
    check("t3_abort_valid", bus.valid, 0);
    bus.req1 = 1'b1;
    tick();
    check("t3_prio_gnt0", bus.gnt0, 1);
    check("t3_prio_gnt1", bus.gnt1, 0);
    tick();
    check("t3_beat", bus.out, 8'hC3);

    // reset mid-transfer
    do_reset();
    bus.req0 = 1'b1;
    bus.in0  = 8'h3C;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_beat", bus.out, 8'h3C);
    end
    rst = 1'b1;
    #1;
    check("t4_rst_gnt0", bus.gnt0, 0);
    check("t4_rst_valid", bus.valid, 0);
    check("t4_rst_out", bus.out, 0);
    check("t4_rst_sel", bus.sel, 0);
    tick();
    check("t4_hold_valid", bus.valid, 0);
    rst = 1'b0;
    bus.req0 = 1'b0;
    tick();
    check("t4_post_valid", bus.valid, 0);
    check("t4_post_out", bus.out, 0);

    // no pre-emption, handover on last
    do_reset();
    bus.req0 = 1'b1;
    bus.in0  = 8'h77;
    bus.in1  = 8'h88;
    tick();
    bus.req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_no_gnt1", bus.gnt1, 0);
      check("t5_gnt0", bus.gnt0, 1);
    end
    bus.last = 1'b1;
    tick();
    check("t5_hand_gnt1", bus.gnt1, 1);
    check("t5_hand_gnt0", bus.gnt0, 0);
    check("t5_hand_out", bus.out, 8'h77);
    bus.last = 1'b0;
    tick();
    check("t5_b1_out", bus.out, 8'h88);
    check("t5_b1_valid", bus.valid, 1);

    idle_in();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
